bcd_seg_scanner: RTL

//  Downstream display stage for the 2-digit BCD counter. Takes the packed count
//  {tens,units} and time-multiplexes it onto one shared 7-segment bus with two digit enables.

---
 rtl/bcd_seg_scanner_if.sv | 29 ++
 rtl/bcd_seg_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scanner_if.sv
// Purpose: display-side bundle between the BCD counter and the 7-segment scanner.
// Latency: none (wires only).
// Backpressure: none; the counter value is sampled once per frame, so no handshake is needed.
interface bcd_seg_scanner_if;
    logic       en;
    logic [7:0] bcd_in;
    logic [6:0] seg_o;
    logic [1:0] dig_o;
    logic       frame_o;
    logic       err_o;

    modport master (
        output en,
        output bcd_in,
        input  seg_o,
        input  dig_o,
        input  frame_o,
        input  err_o
    );

    modport slave (
        input  en,
        input  bcd_in,
        output seg_o,
        output dig_o,
        output frame_o,
        output err_o
    );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Purpose: time-multiplex a 2-digit BCD value onto one 7-segment bus, with blanking and error flag.
// Latency: a new value becomes visible at the next frame reload; seg/dig decode only from registers.
// Backpressure: none; en=0 darkens the display on the next clock and holds the snapshot.
module bcd_seg_scanner #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYC    = 4,
    parameter bit BLANK_LZ     = 1'b1,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    bcd_seg_scanner_if.slave   bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    // Slot end values; a zero-length gap is skipped entirely, so its end value is never used.
    localparam logic [CW-1:0] RD_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_GAP_T = 3'd1;
    localparam logic [2:0] S_TENS  = 3'd2;
    localparam logic [2:0] S_GAP_U = 3'd3;
    localparam logic [2:0] S_UNITS = 3'd4;

    // Entry states after a reload or after the tens slot, honouring a zero-length gap.
    localparam logic [2:0] S_AFTER_LOAD = (BLANK_CYC == 0) ? S_TENS  : S_GAP_T;
    localparam logic [2:0] S_AFTER_TENS = (BLANK_CYC == 0) ? S_UNITS : S_GAP_U;

    logic [2:0]    state;
    logic [CW-1:0] div_cnt;
    logic [7:0]    snap;
    logic          frame_q;
    logic          err_q;
    logic [6:0]    seg_l;
    logic [1:0]    dig_l;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h40;
        endcase
    endfunction

    // Scan sequencer: slot timing, per-frame snapshot and reload pulse.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= S_OFF;
            div_cnt <= '0;
            snap    <= 8'h00;
            frame_q <= 1'b0;
        end else if (!bus.en) begin
            state   <= S_OFF;
            div_cnt <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state)
                S_OFF: begin
                    snap    <= bus.bcd_in;
                    frame_q <= 1'b1;
                    state   <= S_AFTER_LOAD;
                    div_cnt <= '0;
                end
                S_GAP_T: begin
                    if (div_cnt == BLK_LAST) begin
                        state   <= S_TENS;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_TENS: begin
                    if (div_cnt == RD_LAST) begin
                        state   <= S_AFTER_TENS;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP_U: begin
                    if (div_cnt == BLK_LAST) begin
                        state   <= S_UNITS;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_UNITS: begin
                    if (div_cnt == RD_LAST) begin
                        snap    <= bus.bcd_in;
                        frame_q <= 1'b1;
                        state   <= S_AFTER_LOAD;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_OFF;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky invalid-BCD flag, judged on the snapshot one clock after it loads.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else if ((snap[7:4] > 4'd9) || (snap[3:0] > 4'd9)) begin
            err_q <= 1'b1;
        end
    end

    // Digit/segment decode from registered state only; digit enables are one-hot or dark.
    always_comb begin
        seg_l = 7'h00;
        dig_l = 2'b00;
        if (state == S_TENS) begin
            if (!(BLANK_LZ && (snap[7:4] == 4'd0))) begin
                seg_l = enc(snap[7:4]);
                dig_l = 2'b10;
            end
        end else if (state == S_UNITS) begin
            seg_l = enc(snap[3:0]);
            dig_l = 2'b01;
        end
    end

    assign bus.seg_o   = COMMON_ANODE ? ~seg_l : seg_l;
    assign bus.dig_o   = COMMON_ANODE ? ~dig_l : dig_l;
    assign bus.frame_o = frame_q;
    assign bus.err_o   = err_q;
endmodule
